retrosoc_iomux: RTL
===================

// Module: retrosoc_iomux
// PURPOSE
//  Parametrised, runtime-configurable pad multiplexer between retroSoC peripherals and a
//  shared bank of bidirectional pads; replaces hard-wired pin assignment in the top wrapper.
//  Each pad selects one of NUM_FUNCS peripheral functions via a config register.
//  The input path has a 2-flop synchroniser, an optional glitch filter and optional inversion.
//  Configured over a simple valid/ready register port from the SoC peripheral bus.
// PARAMETERS
//  NUM_PADS   8      number of pads (1..16)
//  NUM_FUNCS  4      functions per pad (2..16); SEL_W = $clog2(NUM_FUNCS)
//  FLT_W      4      glitch-filter counter/threshold width
//  FUNC_IDLE  4'b0   per-function value driven on func_in_o when that function is not selected
// PORTS
//  clk_i        in   1                  system clock
//  rst_i        in   1                  synchronous reset, active high
//  reg_valid_i  in   1                  register access request
//  reg_we_i     in   1                  1=write, 0=read
//  reg_addr_i   in   5                  word address
//  reg_wdata_i  in   32                 write data
//  reg_ready_o  out  1                  access done (one-cycle pulse)
//  reg_rdata_o  out  32                 read data, valid while reg_ready_o=1
//  func_out_i   in   NUM_PADS*NUM_FUNCS  peripheral output, index p*NUM_FUNCS+f
//  func_oe_i    in   NUM_PADS*NUM_FUNCS  peripheral output enable (1=drive)
//  func_in_o    out  NUM_PADS*NUM_FUNCS  pad input routed to peripheral
//  pad_in_i     in   NUM_PADS           raw asynchronous pad input
//  pad_out_o    out  NUM_PADS           pad output value
//  pad_oe_o     out  NUM_PADS           pad output enable (1=output)
// BEHAVIOUR
//  Registers: addr p<NUM_PADS -> PADCFG[p]: [SEL_W-1:0] sel, [8] force_in, [9] flt_en, [10] inv_in.
//   addr NUM_PADS -> FLTTHR [FLT_W-1:0]. addr NUM_PADS+1 -> PADSTAT (RO, filtered inputs).
//   Unused bits read 0. sel>=NUM_FUNCS behaves as sel=0.
//  Reset: all PADCFG=0, FLTTHR=0, sync/filter state=0, pad_out_o=0, pad_oe_o=0,
//   func_in_o=FUNC_IDLE pattern, reg_ready_o=0, reg_rdata_o=0.
//  Handshake: reg_ready_o=1 exactly one cycle after a cycle with reg_valid_i=1 and ready=0;
//   a request is never accepted while reg_ready_o=1 (back-to-back = one access per 2 cycles).
//   Writes commit on the acceptance edge; a new config applies to datapath outputs from the next cycle.
//   Out-of-range addr or write to PADSTAT: write ignored, read returns 0, ready still pulses.
//  Output path (registered, 1-cycle latency): pad_out_o[p] <= func_out_i[p][sel];
//   pad_oe_o[p] <= force_in ? 0 : func_oe_i[p][sel].
//  Input path per pad: s1 <= pad_in_i; s2 <= s1 (reset 0).
//   Filter (flt_en=1 and FLTTHR!=0): cnt clears when s2==filt; otherwise it increments, and when
//   cnt==FLTTHR-1 then filt <= s2 and cnt <= 0, so a change must persist FLTTHR cycles.
//   The counter saturates and never wraps. Otherwise filt <= s2 every cycle.
//   FLTTHR changed mid-count: compared against new value next cycle; cnt>=THR-1 commits immediately.
//  func_in_o[p][f] <= (f==sel) ? (filt ^ inv_in) : FUNC_IDLE[f]. Filter off: latency 4 edges from pad_in_i.
//  PADSTAT[p] = filt ^ inv_in.
//  Reset asserted mid-operation: all state returns to reset values on that edge; any in-flight
//   register access is dropped and ready is not pulsed.
// TESTING
//  1 Reset, all PADCFG=0: func_out_i[p*4+0]=1, func_oe_i=1 -> pad_out_o=8'hFF, pad_oe_o=8'hFF after 1 cycle;
//    func_in_o f1..3 = 0.
//  2 Write PADCFG[3]=0x2 -> pad3 follows func 2 from the cycle after ready; pad_in_i[3]=1 -> func_in_o[14]=1 after 4 edges.
//  3 FLTTHR=4, PADCFG[0]=0x200: 3-cycle pulse on pad_in_i[0] -> no change;
//    a 6-cycle high level -> func_in_o[0] rises 7 edges after the input edge.
//  4 PADCFG[5]=0x500 (force_in, inv_in), pad_in_i[5]=0 -> pad_oe_o[5]=0, PADSTAT bit5=1.
//  5 Read addr 31 -> ready pulse, rdata=0; back-to-back valid held high -> ready on every 2nd cycle.
//  6 Assert rst_i during a filter count and a pending write -> all outputs at reset values, PADCFG unchanged from 0.

Source files
------------

// File: rtl/retrosoc_iomux.sv
// retrosoc_iomux: runtime-configurable pad multiplexer between peripherals and a
// shared bank of bidirectional pads. Each pad selects one peripheral function,
// its input goes through a 2-flop synchroniser and an optional glitch filter and
// inversion, and it is configured through a small valid/ready register port.
module retrosoc_iomux #(
   parameter int                   NUM_PADS  = 8,
   parameter int                   NUM_FUNCS = 4,
   parameter int                   FLT_W     = 4,
   parameter logic [NUM_FUNCS-1:0] FUNC_IDLE = '0
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            reg_valid_i,
   input  logic                            reg_we_i,
   input  logic [4:0]                      reg_addr_i,
   input  logic [31:0]                     reg_wdata_i,
   output logic                            reg_ready_o,
   output logic [31:0]                     reg_rdata_o,
   input  logic [NUM_PADS*NUM_FUNCS-1:0]   func_out_i,
   input  logic [NUM_PADS*NUM_FUNCS-1:0]   func_oe_i,
   output logic [NUM_PADS*NUM_FUNCS-1:0]   func_in_o,
   input  logic [NUM_PADS-1:0]             pad_in_i,
   output logic [NUM_PADS-1:0]             pad_out_o,
   output logic [NUM_PADS-1:0]             pad_oe_o
);

   localparam int         SEL_W     = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1;
   localparam int         NPF       = NUM_PADS * NUM_FUNCS;
   localparam logic [4:0] ADDR_THR  = 5'(NUM_PADS);
   localparam logic [4:0] ADDR_STAT = 5'(NUM_PADS + 1);

   // configuration registers
   logic [NUM_PADS-1:0][SEL_W-1:0] sel_q;
   logic [NUM_PADS-1:0]            force_q;
   logic [NUM_PADS-1:0]            flten_q;
   logic [NUM_PADS-1:0]            inv_q;
   logic [FLT_W-1:0]               thr_q;

   // input path state
   logic [NUM_PADS-1:0]            s1_q;
   logic [NUM_PADS-1:0]            s2_q;
   logic [NUM_PADS-1:0]            filt_q;
   logic [NUM_PADS-1:0][FLT_W-1:0] cnt_q;

   logic [NUM_PADS-1:0]            filt_d;
   logic [NUM_PADS-1:0][FLT_W-1:0] cnt_d;
   logic [NUM_PADS-1:0]            pad_out_d;
   logic [NUM_PADS-1:0]            pad_oe_d;
   logic [NPF-1:0]                 func_in_d;
   logic [NUM_PADS-1:0]            pad_stat;
   logic [FLT_W-1:0]               thr_m1;
   logic                           accept;
   logic [31:0]                    rd_data;

   assign pad_stat = filt_q ^ inv_q;
   assign thr_m1   = thr_q - 1'b1;
   assign accept   = reg_valid_i & ~reg_ready_o;

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      logic [NUM_FUNCS-1:0] fo;
      logic [NUM_FUNCS-1:0] fe;
      logic [SEL_W-1:0]     sel_eff;
      logic                 flt_on;
      logic                 commit;

      assign fo = func_out_i[p*NUM_FUNCS +: NUM_FUNCS];
      assign fe = func_oe_i[p*NUM_FUNCS +: NUM_FUNCS];
      // an out-of-range selector falls back to function 0
      assign sel_eff = (32'(sel_q[p]) < NUM_FUNCS) ? sel_q[p] : '0;

      assign pad_out_d[p] = fo[sel_eff];
      assign pad_oe_d[p]  = ~force_q[p] & fe[sel_eff];

      // with the filter off the synchronised value passes straight through;
      // a threshold already exceeded after a mid-count change commits at once
      assign flt_on   = flten_q[p] & (thr_q != '0);
      assign commit   = ~flt_on | ((s2_q[p] != filt_q[p]) & (cnt_q[p] >= thr_m1));
      assign filt_d[p] = commit ? s2_q[p] : filt_q[p];
      assign cnt_d[p]  = (commit | (s2_q[p] == filt_q[p])) ? '0 :
                         ((cnt_q[p] == '1) ? cnt_q[p] : cnt_q[p] + 1'b1);

      for (genvar f = 0; f < NUM_FUNCS; f++) begin : g_func
         assign func_in_d[p*NUM_FUNCS+f] = (sel_eff == SEL_W'(f)) ? pad_stat[p] : FUNC_IDLE[f];
      end
   end

   // register read mux; unused bits and unmapped addresses read as zero
   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         if (reg_addr_i == 5'(p)) begin
            rd_data[SEL_W-1:0] = sel_q[p];
            rd_data[8]         = force_q[p];
            rd_data[9]         = flten_q[p];
            rd_data[10]        = inv_q[p];
         end
      end
      if (reg_addr_i == ADDR_THR) begin
         rd_data[FLT_W-1:0] = thr_q;
      end
      if (reg_addr_i == ADDR_STAT) begin
         rd_data[NUM_PADS-1:0] = pad_stat;
      end
   end

   // register port: one access per ready pulse, writes commit on the accept edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sel_q       <= '0;
         force_q     <= '0;
         flten_q     <= '0;
         inv_q       <= '0;
         thr_q       <= '0;
         reg_ready_o <= 1'b0;
         reg_rdata_o <= '0;
      end else begin
         reg_ready_o <= accept;
         reg_rdata_o <= (accept & ~reg_we_i) ? rd_data : '0;
         if (accept & reg_we_i) begin
            for (int p = 0; p < NUM_PADS; p++) begin
               if (reg_addr_i == 5'(p)) begin
                  sel_q[p]   <= reg_wdata_i[SEL_W-1:0];
                  force_q[p] <= reg_wdata_i[8];
                  flten_q[p] <= reg_wdata_i[9];
                  inv_q[p]   <= reg_wdata_i[10];
               end
            end
            if (reg_addr_i == ADDR_THR) begin
               thr_q <= reg_wdata_i[FLT_W-1:0];
            end
         end
      end
   end

   // pad datapath: synchroniser, glitch filter and registered pad/function outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q      <= '0;
         s2_q      <= '0;
         filt_q    <= '0;
         cnt_q     <= '0;
         pad_out_o <= '0;
         pad_oe_o  <= '0;
         func_in_o <= {NUM_PADS{FUNC_IDLE}};
      end else begin
         s1_q      <= pad_in_i;
         s2_q      <= s1_q;
         filt_q    <= filt_d;
         cnt_q     <= cnt_d;
         pad_out_o <= pad_out_d;
         pad_oe_o  <= pad_oe_d;
         func_in_o <= func_in_d;
      end
   end

endmodule
